// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding, counter
// width helper and bit-order encoding constants.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Values accepted by the MSB_FIRST parameter.
  localparam bit LSB_FIRST_ENC = 1'b0;
  localparam bit MSB_FIRST_ENC = 1'b1;

  // Beat counter width: wide enough to hold WIDTH (the parity beat index).
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake bundle for piso_serializer.
//   load_valid/load_ready/p_in : parallel load side
//   s_out/s_valid/s_ready/s_last : serial beat side
// master = producer/consumer environment, slave = the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] p_in;
  logic             s_out;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;

  modport master (
    output load_valid, p_in, s_ready,
    input  load_ready, s_out, s_valid, s_last
  );

  modport slave (
    input  load_valid, p_in, s_ready,
    output load_ready, s_out, s_valid, s_last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// A word captured on a load handshake is shifted out one bit per accepted
// beat; s_last marks the final beat, on which the next word may be loaded
// so frames stream without a gap.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - piso_serializer_if.slave (load_valid, load_ready, p_in,
//           s_out, s_valid, s_ready, s_last)
// Parameters: WIDTH (2..64), MSB_FIRST (0: bit 0 first, 1: bit WIDTH-1 first)
// Option macro PISO_SERIALIZER_PARITY_EN: appends an even-parity beat.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = LSB_FIRST_ENC
) (
  input logic               clk,
  input logic               rst_n,
  piso_serializer_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             s_out_q;
  logic             s_valid_q;
  logic             s_last_q;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  logic [WIDTH-1:0] shifted;
  logic             next_bit;
  logic             first_bit;
  logic             beat_acc;
  logic             load_acc;
  logic             last_data;

  // Shift toward the output end with zero fill; next_bit is what lands there.
  assign shifted   = (MSB_FIRST == MSB_FIRST_ENC) ? (sreg << 1) : (sreg >> 1);
  assign next_bit  = (MSB_FIRST == MSB_FIRST_ENC) ? sreg[WIDTH-2] : sreg[1];
  assign first_bit = (MSB_FIRST == MSB_FIRST_ENC) ? bus.p_in[WIDTH-1] : bus.p_in[0];

  assign beat_acc  = s_valid_q && bus.s_ready;
  assign load_acc  = bus.load_valid && bus.load_ready;
  assign last_data = (cnt == CW'(WIDTH - 1));

  // Early ready on the final beat lets the next word follow with no gap.
  assign bus.load_ready = (state == IDLE) || (s_last_q && bus.s_ready);

  assign bus.s_out   = s_out_q;
  assign bus.s_valid = s_valid_q;
  assign bus.s_last  = s_last_q;

  // FSM, shifter and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_acc) begin
            state     <= SHIFT;
            sreg      <= bus.p_in;
            cnt       <= '0;
            s_out_q   <= first_bit;
            s_valid_q <= 1'b1;
            s_last_q  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q     <= ^bus.p_in;
`endif
          end
        end

        SHIFT: begin
          if (beat_acc) begin
            if (last_data) begin
`ifdef PISO_SERIALIZER_PARITY_EN
              state    <= PARITY;
              sreg     <= '0;
              cnt      <= CW'(cnt + CW'(1));
              s_out_q  <= par_q;
              s_last_q <= 1'b1;
`else
              if (load_acc) begin
                sreg      <= bus.p_in;
                cnt       <= '0;
                s_out_q   <= first_bit;
                s_valid_q <= 1'b1;
                s_last_q  <= 1'b0;
              end else begin
                state     <= IDLE;
                sreg      <= '0;
                cnt       <= '0;
                s_out_q   <= 1'b0;
                s_valid_q <= 1'b0;
                s_last_q  <= 1'b0;
              end
`endif
            end else begin
              sreg     <= shifted;
              cnt      <= CW'(cnt + CW'(1));
              s_out_q  <= next_bit;
`ifndef PISO_SERIALIZER_PARITY_EN
              // Flag the beat that will be presented next if it is the last.
              s_last_q <= (cnt == CW'(WIDTH - 2));
`endif
            end
          end
        end

`ifdef PISO_SERIALIZER_PARITY_EN
        PARITY: begin
          if (beat_acc) begin
            if (load_acc) begin
              state     <= SHIFT;
              sreg      <= bus.p_in;
              cnt       <= '0;
              s_out_q   <= first_bit;
              s_valid_q <= 1'b1;
              s_last_q  <= 1'b0;
              par_q     <= ^bus.p_in;
            end else begin
              state     <= IDLE;
              sreg      <= '0;
              cnt       <= '0;
              s_out_q   <= 1'b0;
              s_valid_q <= 1'b0;
              s_last_q  <= 1'b0;
            end
          end
        end
`endif

        default: begin
          state     <= IDLE;
          sreg      <= '0;
          cnt       <= '0;
          s_out_q   <= 1'b0;
          s_valid_q <= 1'b0;
          s_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an LSB-first and an MSB-first
// instance (WIDTH=8) are driven in lockstep from a table of frames, followed
// by stall, back-to-back and mid-frame reset sequences.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk;
  logic rst_n;

  piso_serializer_if #(.WIDTH(8)) bus0 ();
  piso_serializer_if #(.WIDTH(8)) bus1 ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Both instances always see the same inputs.
  logic       load_valid;
  logic [7:0] p_in;
  logic       s_ready;
  assign bus0.load_valid = load_valid;
  assign bus1.load_valid = load_valid;
  assign bus0.p_in       = p_in;
  assign bus1.p_in       = p_in;
  assign bus0.s_ready    = s_ready;
  assign bus1.s_ready    = s_ready;

  // Expected beat sequences: bit i of exp_lsb/exp_msb is beat i.
  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
    logic       exp_par;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int i, input logic e0, input logic e1,
                          input logic last);
    chk($sformatf("%s b%0d lsb s_valid", tag, i), 8'(bus0.s_valid), 8'd1);
    chk($sformatf("%s b%0d lsb s_out", tag, i),   8'(bus0.s_out),   8'(e0));
    chk($sformatf("%s b%0d lsb s_last", tag, i),  8'(bus0.s_last),  8'(last));
    chk($sformatf("%s b%0d msb s_valid", tag, i), 8'(bus1.s_valid), 8'd1);
    chk($sformatf("%s b%0d msb s_out", tag, i),   8'(bus1.s_out),   8'(e1));
    chk($sformatf("%s b%0d msb s_last", tag, i),  8'(bus1.s_last),  8'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " lsb s_valid"},    8'(bus0.s_valid),    8'd0);
    chk({tag, " lsb s_out"},      8'(bus0.s_out),      8'd0);
    chk({tag, " lsb s_last"},     8'(bus0.s_last),     8'd0);
    chk({tag, " lsb load_ready"}, 8'(bus0.load_ready), 8'd1);
    chk({tag, " msb s_valid"},    8'(bus1.s_valid),    8'd0);
    chk({tag, " msb load_ready"}, 8'(bus1.load_ready), 8'd1);
  endtask

  // Load one word and check every beat with s_ready held high.
  task automatic run_frame(input string tag, input vec_t v);
    logic e0, e1;
    load_valid = 1'b1;
    p_in       = v.word;
    #1;
    chk({tag, " load_ready"}, 8'(bus0.load_ready), 8'd1);
    step();
    load_valid = 1'b0;
    p_in       = 8'h00;
    for (int i = 0; i < NB; i++) begin
      #1;
      e0 = (i < 8) ? v.exp_lsb[i] : v.exp_par;
      e1 = (i < 8) ? v.exp_msb[i] : v.exp_par;
      chk_beat(tag, i, e0, e1, i == NB - 1);
      step();
    end
    #1;
    chk_idle({tag, " after"});
  endtask

  initial begin
    logic [7:0] hold_out;
    logic [15:0] b2b;
    logic e0;
    vec_t v;

    vecs[0] = '{word: 8'h1E, exp_lsb: 8'h1E, exp_msb: 8'h78, exp_par: 1'b0};
    vecs[1] = '{word: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5, exp_par: 1'b0};
    vecs[2] = '{word: 8'h0D, exp_lsb: 8'h0D, exp_msb: 8'hB0, exp_par: 1'b1};
    vecs[3] = '{word: 8'h80, exp_lsb: 8'h80, exp_msb: 8'h01, exp_par: 1'b1};
    vecs[4] = '{word: 8'h07, exp_lsb: 8'h07, exp_msb: 8'hE0, exp_par: 1'b1};
    vecs[5] = '{word: 8'h03, exp_lsb: 8'h03, exp_msb: 8'hC0, exp_par: 1'b0};

    rst_n      = 1'b0;
    load_valid = 1'b0;
    p_in       = 8'h00;
    s_ready    = 1'b1;
    step();
    step();
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("vec%0d", k), vecs[k]);
    end

    // Stall on beat 3 of 0x1E; a load offered during the stall is ignored.
    v = vecs[0];
    load_valid = 1'b1;
    p_in       = v.word;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1;
      chk_beat("stall", i, (i < 8) ? v.exp_lsb[i] : v.exp_par,
               (i < 8) ? v.exp_msb[i] : v.exp_par, i == NB - 1);
      if (i == 2) begin
        s_ready    = 1'b0;
        load_valid = 1'b1;
        p_in       = 8'hAA;
        for (int c = 0; c < 3; c++) begin
          step();
          #1;
          hold_out = {6'd0, bus1.s_out, bus0.s_out};
          chk($sformatf("stall hold%0d s_out", c), hold_out, {6'd0, v.exp_msb[2], v.exp_lsb[2]});
          chk($sformatf("stall hold%0d s_valid", c), 8'({bus1.s_valid, bus0.s_valid}), 8'd3);
          chk($sformatf("stall hold%0d s_last", c), 8'({bus1.s_last, bus0.s_last}), 8'd0);
          chk($sformatf("stall hold%0d load_ready", c), 8'(bus0.load_ready), 8'd0);
        end
        s_ready    = 1'b1;
        load_valid = 1'b0;
        p_in       = 8'h00;
      end
      step();
    end
    #1;
    chk_idle("stall after");

    // Back-to-back 0x0F then 0xF0 with load_valid held (checked on LSB-first).
    b2b = 16'hF00F;
    load_valid = 1'b1;
    p_in       = 8'h0F;
    step();
    p_in = 8'hF0;
    for (int i = 0; i < 2 * NB; i++) begin
      #1;
      if (i % NB < 8) e0 = b2b[(i / NB) * 8 + (i % NB)];
      else            e0 = 1'b0;  // parity of 0x0F and 0xF0 is even
      chk($sformatf("b2b b%0d s_valid", i),    8'(bus0.s_valid), 8'd1);
      chk($sformatf("b2b b%0d s_out", i),      8'(bus0.s_out),   8'(e0));
      chk($sformatf("b2b b%0d s_last", i),     8'(bus0.s_last),  8'((i % NB) == NB - 1));
      chk($sformatf("b2b b%0d load_ready", i), 8'(bus0.load_ready), 8'((i % NB) == NB - 1));
      step();
      if (i == NB - 1) begin
        load_valid = 1'b0;
        p_in       = 8'h00;
      end
    end
    #1;
    chk_idle("b2b after");

    // Reset asserted while beat 4 of 0xFF is presented.
    load_valid = 1'b1;
    p_in       = 8'hFF;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_beat("pre_rst", i, 1'b1, 1'b1, 1'b0);
      step();
    end
    #1;
    chk_beat("pre_rst", 3, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    #1;
    chk_idle("midrst");
    rst_n = 1'b1;
    run_frame("post_rst", '{word: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80, exp_par: 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides. A WIDTH-bit word is captured through a load handshake and shifted out one bit per accepted serial beat, in a configurable bit order. The block flags the final beat and can accept the next word on that beat, so frames stream with no gap. It sits between a parallel producer, such as a register file or FIFO, and a serial link or PHY front-end.

## Interface
Parameters:
- WIDTH, default 8: parallel word width; legal range 2..64.
- MSB_FIRST, default 0: 0 shifts bit 0 first; 1 shifts bit WIDTH-1 first.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- load_valid  input  1  producer offers p_in.
- load_ready  output  1  block can capture a word this cycle.
- p_in  input  WIDTH  parallel word, sampled when load_valid && load_ready.
- s_out  output  1  current serial bit.
- s_valid  output  1  s_out holds a valid beat.
- s_ready  input  1  consumer accepts the beat this cycle.
- s_last  output  1  the current beat is the final beat of the frame.

## Operation
- Reset (rst_n low at a clock edge) sets the state to IDLE and clears the shift register and beat counter.
- Output values after reset: s_out=0, s_valid=0, s_last=0, load_ready=1.
- Reset mid-frame aborts the frame. The remaining bits are discarded and no s_last is emitted.
- States:
  - IDLE: s_valid=0, s_out=0. On load accept, capture p_in and go to SHIFT.
  - SHIFT: s_valid=1. On each s_valid && s_ready, shift one position toward the output end, zero-fill the vacated bit, and increment the counter.
  - PARITY: exists only with the Configuration macro defined (see Configuration).
- Leaving SHIFT, when the final data beat is accepted:
  - If the macro is defined, go to PARITY.
  - Otherwise, if a load is accepted in the same cycle, capture the new word and stay in SHIFT with the counter cleared.
  - Otherwise, go to IDLE.
- Bit order: s_out = sreg[0] when MSB_FIRST=0; s_out = sreg[WIDTH-1] when MSB_FIRST=1.
- Beat counter width: $clog2(WIDTH+1). Counter values above the final beat are unreachable.
- load_ready = (state==IDLE) || (s_last && s_ready). This is combinational from s_ready by design, and it is the only combinational input-to-output path.
- s_last is high exactly on the final beat of the frame.
- While s_valid && !s_ready: s_out, s_valid, s_last and all internal state hold unchanged.
- load_valid outside a load_ready cycle is ignored, and p_in is not sampled.

## Timing
- Load accepted at edge N: the first bit appears on s_out with s_valid=1 after edge N (cycle N+1).
- With s_ready held high, a frame occupies WIDTH consecutive beats, or WIDTH+1 with the macro defined.
- Back-to-back streaming: when a load is accepted on the last beat, the new frame's first bit appears on the very next cycle, with no idle cycle between frames.
- A frame with no load pending returns to IDLE: s_valid=0 on the cycle after the last beat is accepted.
- Stalls of any length are legal. The frame resumes on the first cycle s_ready returns high.

## Configuration
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - After the WIDTH data beats, one extra beat carries the even-parity bit (XOR of the captured word).
  - The parity bit is registered at load time.
  - s_last moves from the final data beat to the parity beat.
  - load_ready's early assertion applies on the parity beat.
- Not defined: no PARITY state, no parity register, and frames are exactly WIDTH beats.

## Structure
- Shared package piso_pkg holds:
  - the state typedef (IDLE, SHIFT, PARITY);
  - a localparam function computing counter width from WIDTH;
  - the MSB_FIRST encoding constants.
- Single module. No sub-module is warranted; the shifter, counter and FSM together are under 200 lines.

## Test plan
- WIDTH=8, MSB_FIRST=0, s_ready=1, load 0x1E -> s_out 0,1,1,1,1,0,0,0; s_last on beat 8; s_valid=0 on the following cycle.
- WIDTH=8, MSB_FIRST=1, load 0x1E -> s_out 0,0,0,1,1,1,1,0.
- Stall: load 0x1E (LSB-first), drop s_ready for 3 cycles while beat 3 is presented -> s_out, s_valid and s_last hold during the stall; the remaining bits follow in order with no loss or duplication.
- Back-to-back: load_valid held with 0x0F then 0xF0 -> 16 contiguous beats 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; load_ready pulses on beat 8; s_last on beats 8 and 16.
- Reset mid-frame: assert rst_n=0 at beat 4 of 0xFF -> on the next cycle s_valid=0, s_out=0, s_last=0, load_ready=1; a fresh load of 0x01 then serializes correctly.
- With PISO_SERIALIZER_PARITY_EN defined, load 0x07 -> 8 data beats then a parity beat with s_out=1 and s_last=1; load 0x03 -> parity beat with s_out=0.
